imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Sequences and shares the single instruction-ROM port between CPU fetch and a UART program loader.
- In RUN, the fetch address drives the memory and the CPU runs freely.
- On a load request, the block stalls the CPU, drains the in-flight fetch, and gives the port to the loader.
- After loading, it holds the CPU in reset for a fixed time, then releases it.
- Sits between the fetch unit, the UART receiver and the prgrom instance at top level.

Parameters:
- ADDR_W, 14, word-address width (PC[15:2]).
- DATA_W, 32, instruction width.
- RESET_HOLD, 4, cycles cpu_rst stays high after a load ends; must be >= 1.
- TIMEOUT, 1000000, idle cycles allowed in LOAD before abort; must be >= 2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- ld_start  in  1  pulse: request load mode.
- ld_wen  in  1  loader write strobe, one word per cycle.
- ld_addr  in  ADDR_W  loader word address.
- ld_wdata  in  DATA_W  loader word.
- ld_done  in  1  pulse: loader finished.
- fetch_addr  in  ADDR_W  word address from the fetch unit.
- mem_addr  out  ADDR_W  to ROM addra.
- mem_wdata  out  DATA_W  to ROM dina.
- mem_we  out  1  to ROM wea.
- cpu_stall  out  1  fetch unit holds PC while high.
- cpu_rst  out  1  forces PC and register file to reset while high.
- busy  out  1  high in any state other than RUN.
- ld_count  out  ADDR_W+1  words written in the current or last load.
- ld_err  out  1  last load aborted by timeout; sticky until the next ld_start is accepted.

Behaviour:
- States: RUN, DRAIN, LOAD, RELEASE.
- Reset value: state = RUN.
- Outputs while reset is high:
  - mem_we = 0, mem_wdata = 0, ld_count = 0, ld_err = 0.
  - cpu_stall = 0, busy = 0.
  - cpu_rst = 0; the external reset already resets the CPU.
  - Hold counter and timeout counter = 0.
- RUN:
  - mem_addr = fetch_addr, mem_we = 0.
  - ld_wen and ld_done are ignored.
  - ld_start -> DRAIN; cpu_stall goes high on the same edge (registered output).
  - Entering DRAIN clears ld_count and ld_err.
- DRAIN:
  - Lasts exactly 1 cycle so the ROM read in flight completes.
  - cpu_stall = 1, mem_we = 0, mem_addr = fetch_addr.
  - Always -> LOAD.
- LOAD:
  - cpu_stall = 1; mem_addr = ld_addr; mem_wdata = ld_wdata; mem_we = ld_wen (combinational pass-through, zero latency).
  - ld_count increments per ld_wen and saturates at 2^ADDR_W.
  - Timeout counter resets on every ld_wen and on entry to LOAD; otherwise it increments.
  - ld_done -> RELEASE. If ld_wen is high in the same cycle, that write is still performed and counted.
  - Timeout counter reaching TIMEOUT-1 with no ld_wen -> RELEASE and ld_err = 1. ld_done wins over timeout in the same cycle (ld_err stays 0).
  - ld_start is ignored in this state.
- RELEASE:
  - cpu_stall = 1, cpu_rst = 1, mem_we = 0, mem_addr = fetch_addr.
  - Stays RESET_HOLD cycles, then -> RUN. cpu_stall and cpu_rst drop together on that edge.
  - ld_start is ignored in this state.
- busy = (state != RUN).
- Asynchronous reset at any point returns to RUN immediately. A partially loaded image is kept, but ld_count and ld_err are cleared.
- No write is ever issued outside LOAD.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - Adds output ld_csum [DATA_W-1:0], a running XOR of every word written in LOAD.
  - Cleared on entering DRAIN and on reset; holds its value after the load.
- Undefined:
  - No port, no logic; port list is exactly as above.

Decomposition:
- Shared package imem_pkg:
  - State enum.
  - Parameter defaults.
  - Localparam for the count width (ADDR_W+1).
- One natural sub-module: imem_load_timer.
  - Loadable down counter used for both the RESET_HOLD hold count and the TIMEOUT idle count.
  - Ports: clear, enable, expire.

Test Plan:
- Reset then RUN, fetch_addr = 0x0005 -> mem_addr = 0x0005, mem_we = 0, cpu_stall = 0, busy = 0.
- ld_start pulse -> cpu_stall = 1 on the next edge; DRAIN for 1 cycle; in LOAD, ld_wen with ld_addr = 0x0010, ld_wdata = 0xDEADBEEF -> mem_we = 1 and mem_addr = 0x0010 in the same cycle; ld_count = 1.
- 3 writes, then ld_done together with a 4th write -> ld_count = 4; cpu_rst high for exactly 4 cycles; then RUN with cpu_stall = 0 and ld_err = 0.
- TIMEOUT = 8, no ld_wen after entering LOAD -> RELEASE after 8 cycles, ld_err = 1; a later ld_start clears ld_err.
- ld_wen and ld_done in RUN, and ld_start in LOAD -> no write, no state change, ld_count unchanged.
- Assert reset mid-LOAD after 2 writes -> state RUN, all outputs at reset values. With IMEM_LOAD_CHECKSUM_EN: writes 0x0000FFFF then 0xFFFF0000 -> ld_csum = 0xFFFFFFFF.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-ROM load controller:
//   - default parameter values
//   - controller state enum
//   - width helpers for the load word counter and the shared hold/idle timer
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W     = 14;       // word address, PC[15:2]
    localparam int unsigned IMEM_DATA_W     = 32;       // instruction width
    localparam int unsigned IMEM_RESET_HOLD = 4;        // cpu_rst cycles after a load
    localparam int unsigned IMEM_TIMEOUT    = 1000000;  // idle LOAD cycles before abort

    // Load counter must be able to hold 2^ADDR_W, hence one extra bit.
    localparam int unsigned IMEM_CNT_W      = IMEM_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_LOAD,
        ST_RELEASE
    } imem_state_t;

    function automatic int unsigned count_width(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    // One down counter serves both the release hold and the LOAD idle timeout,
    // so it is sized for the larger of the two reload values.
    function automatic int unsigned timer_width(input int unsigned hold,
                                                input int unsigned timeout);
        int unsigned m;
        m = (hold > timeout) ? hold : timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/imem_load_timer.sv
// -----------------------------------------------------------------------------
// imem_load_timer
// Loadable down counter. Reloads from load_val on clear, counts down while
// enabled and stops at zero; expire is high whenever the count is zero.
// Ports:
//   clock, reset  - clock, asynchronous active-high reset (count -> 0)
//   clear         - load count from load_val (wins over enable)
//   load_val      - reload value
//   enable        - decrement by one (saturates at zero)
//   expire        - count == 0
// -----------------------------------------------------------------------------
module imem_load_timer #(
    parameter int unsigned W = 20
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// imem_load_ctrl
// Shares the single instruction-ROM port between CPU fetch and a UART program
// loader. RUN: fetch owns the port. A load request stalls the CPU, waits one
// cycle for the in-flight fetch (DRAIN), hands the port to the loader (LOAD),
// then holds the CPU in reset for RESET_HOLD cycles (RELEASE) before resuming.
//
// Optional feature (macro IMEM_LOAD_CHECKSUM_EN): adds output ld_csum, a
// running XOR of every word written in LOAD, cleared on entry to DRAIN.
//
// Ports:
//   clock, reset   - clock, asynchronous active-high reset
//   ld_start       - pulse: request load mode (honoured only in RUN)
//   ld_wen         - loader write strobe
//   ld_addr        - loader word address
//   ld_wdata       - loader word
//   ld_done        - pulse: loader finished
//   fetch_addr     - fetch unit word address
//   mem_addr       - ROM addra
//   mem_wdata      - ROM dina
//   mem_we         - ROM wea (only ever high in LOAD)
//   cpu_stall      - fetch unit holds PC
//   cpu_rst        - CPU held in reset
//   busy           - not in RUN
//   ld_count       - words written in the current/last load (saturating)
//   ld_err         - last load aborted by idle timeout (sticky)
//   ld_csum        - XOR of loaded words (IMEM_LOAD_CHECKSUM_EN only)
// -----------------------------------------------------------------------------
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W     = IMEM_ADDR_W,
    parameter int unsigned DATA_W     = IMEM_DATA_W,
    parameter int unsigned RESET_HOLD = IMEM_RESET_HOLD,
    parameter int unsigned TIMEOUT    = IMEM_TIMEOUT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            ld_start,
    input  logic                            ld_wen,
    input  logic [ADDR_W-1:0]               ld_addr,
    input  logic [DATA_W-1:0]               ld_wdata,
    input  logic                            ld_done,
    input  logic [ADDR_W-1:0]               fetch_addr,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic                            mem_we,
    output logic                            cpu_stall,
    output logic                            cpu_rst,
    output logic                            busy,
    output logic [count_width(ADDR_W)-1:0]  ld_count,
`ifdef IMEM_LOAD_CHECKSUM_EN
    output logic                            ld_err,
    output logic [DATA_W-1:0]               ld_csum
`else
    output logic                            ld_err
`endif
);

    localparam int unsigned CNT_W = count_width(ADDR_W);
    localparam int unsigned TMR_W = timer_width(RESET_HOLD, TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};
    // Reload values: the timer expires after load_val further enabled cycles,
    // giving TIMEOUT idle LOAD cycles and RESET_HOLD RELEASE cycles.
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(RESET_HOLD - 1);

    imem_state_t      state;
    imem_state_t      state_nx;

    logic             tmr_clear;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_load;
    logic             tmr_expire;
    logic             idle_abort;

    imem_load_timer #(
        .W (TMR_W)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (tmr_clear),
        .load_val (tmr_load),
        .enable   (tmr_en),
        .expire   (tmr_expire)
    );

    // Idle timeout in LOAD; ld_done in the same cycle takes precedence.
    assign idle_abort = (state == ST_LOAD) && tmr_expire && !ld_wen && !ld_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        tmr_load  = TO_LOAD;
        mem_addr  = fetch_addr;
        mem_wdata = '0;
        mem_we    = 1'b0;

        case (state)
            ST_RUN: begin
                if (ld_start) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nx  = ST_LOAD;
                tmr_clear = 1'b1;
                tmr_load  = TO_LOAD;
            end
            ST_LOAD: begin
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
                mem_we    = ld_wen;
                if (ld_done || (tmr_expire && !ld_wen)) begin
                    state_nx  = ST_RELEASE;
                    tmr_clear = 1'b1;
                    tmr_load  = HOLD_LOAD;
                end else if (ld_wen) begin
                    tmr_clear = 1'b1;
                    tmr_load  = TO_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (tmr_expire) begin
                    state_nx = ST_RUN;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_nx = ST_RUN;
            end
        endcase
    end

    // Decoded straight from the state register, so these change only on clock
    // edges; cpu_stall and cpu_rst drop on the same RELEASE->RUN edge.
    assign busy      = (state != ST_RUN);
    assign cpu_stall = (state != ST_RUN);
    assign cpu_rst   = (state == ST_RELEASE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if ((state == ST_RUN) && ld_start) begin
            ld_count <= '0;
            ld_err   <= 1'b0;
        end else if (state == ST_LOAD) begin
            if (ld_wen && (ld_count != CNT_MAX)) begin
                ld_count <= ld_count + CNT_W'(1);
            end
            if (idle_abort) begin
                ld_err <= 1'b1;
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_csum <= '0;
        end else if ((state == ST_RUN) && ld_start) begin
            ld_csum <= '0;
        end else if ((state == ST_LOAD) && ld_wen) begin
            ld_csum <= ld_csum ^ ld_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_load_ctrl
// Self-checking bench for imem_load_ctrl. Inputs are driven 1 time unit after
// the rising edge; outputs are sampled mid-cycle. Expected values come from
// what the loader did: number of writes (saturating), XOR of written words,
// and how the session ended.
// -----------------------------------------------------------------------------
module tb_imem_load_ctrl;

    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned RH   = 4;
    localparam int unsigned TO   = 8;
    localparam int unsigned CMAX = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          ld_start;
    logic          ld_wen;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_done;
    logic [AW-1:0] fetch_addr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          cpu_stall;
    logic          cpu_rst;
    logic          busy;
    logic [AW:0]   ld_count;
    logic          ld_err;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DW-1:0] ld_csum;
`endif

    int            n_checks = 0;
    int            n_fail   = 0;

    // reference model state
    int unsigned   n_wr;
    logic [DW-1:0] m_csum;
    logic          m_err;

    imem_load_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RESET_HOLD (RH),
        .TIMEOUT    (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ld_start   (ld_start),
        .ld_wen     (ld_wen),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_done    (ld_done),
        .fetch_addr (fetch_addr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .cpu_stall  (cpu_stall),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .ld_count   (ld_count),
`ifdef IMEM_LOAD_CHECKSUM_EN
        .ld_csum    (ld_csum),
`endif
        .ld_err     (ld_err)
    );

    always #5 clock = ~clock;

    function automatic logic [AW:0] exp_count(input int unsigned n);
        return (n < CMAX) ? (AW+1)'(n) : (AW+1)'(CMAX);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ld_start = 1'b0;
        ld_wen   = 1'b0;
        ld_done  = 1'b0;
    endtask

    // Request a load from RUN, check the single DRAIN cycle, land in LOAD.
    task automatic start_load();
        ld_start   = 1'b1;
        fetch_addr = AW'($urandom);
        step();
        ld_start   = 1'b0;
        ld_wen     = 1'b1;
        ld_addr    = AW'($urandom);
        ld_wdata   = $urandom;
        fetch_addr = AW'($urandom);
        #1;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL drain_stall: got %b want 1", cpu_stall); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", busy); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL drain_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== fetch_addr) begin n_fail++; $display("FAIL drain_addr: got %h want %h", mem_addr, fetch_addr); end
        n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL drain_rst: got %b want 0", cpu_rst); end
        n_checks++; if (ld_count !== '0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", ld_count); end
        n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b want 0", ld_err); end
`ifdef IMEM_LOAD_CHECKSUM_EN
        n_checks++; if (ld_csum !== '0) begin n_fail++; $display("FAIL drain_csum: got %h want 0", ld_csum); end
`endif
        step();
        ld_wen = 1'b0;
        n_wr   = 0;
        m_csum = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
        ld_wen     = 1'b1;
        ld_addr    = a;
        ld_wdata   = d;
        ld_done    = done;
        fetch_addr = AW'($urandom);
        #1;
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL load_we: got %b want 1", mem_we); end
        n_checks++; if (mem_addr !== a) begin n_fail++; $display("FAIL load_addr: got %h want %h", mem_addr, a); end
        n_checks++; if (mem_wdata !== d) begin n_fail++; $display("FAIL load_wdata: got %h want %h", mem_wdata, d); end
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL load_stall: got %b want 1", cpu_stall); end
        n_wr++;
        m_csum = m_csum ^ d;
        step();
        ld_wen  = 1'b0;
        ld_done = 1'b0;
    endtask

    // A LOAD cycle with no write; ld_start is thrown in randomly and must be ignored.
    task automatic do_idle(input logic done);
        ld_wen     = 1'b0;
        ld_done    = done;
        ld_start   = 1'($urandom_range(0, 1));
        ld_addr    = AW'($urandom);
        fetch_addr = AW'($urandom);
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b want 0", mem_we); end
        n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL idle_rst: got %b want 0", cpu_rst); end
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL idle_stall: got %b want 1", cpu_stall); end
        step();
        ld_start = 1'b0;
        ld_done  = 1'b0;
    endtask

    // Count cpu_rst cycles (loader inputs randomly active, must cause no write),
    // then check the RUN state that follows.
    task automatic finish_release(input logic exp_err);
        int n;
        n = 0;
        while ((cpu_rst === 1'b1) && (n < int'(RH) + 4)) begin
            ld_wen     = 1'($urandom_range(0, 1));
            ld_done    = 1'($urandom_range(0, 1));
            ld_start   = 1'($urandom_range(0, 1));
            ld_addr    = AW'($urandom);
            fetch_addr = AW'($urandom);
            #1;
            n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rel_we: got %b want 0", mem_we); end
            n_checks++; if (mem_addr !== fetch_addr) begin n_fail++; $display("FAIL rel_addr: got %h want %h", mem_addr, fetch_addr); end
            n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rel_stall: got %b want 1", cpu_stall); end
            step();
            n++;
        end
        idle_inputs();
        m_err = exp_err;
        #1;
        n_checks++; if (n != int'(RH)) begin n_fail++; $display("FAIL rel_len: got %0d want %0d", n, RH); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL run_stall: got %b want 0", cpu_stall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_busy: got %b want 0", busy); end
        n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL run_rst: got %b want 0", cpu_rst); end
        n_checks++; if (ld_count !== exp_count(n_wr)) begin n_fail++; $display("FAIL run_count: got %0d want %0d", ld_count, exp_count(n_wr)); end
        n_checks++; if (ld_err !== exp_err) begin n_fail++; $display("FAIL run_err: got %b want %b", ld_err, exp_err); end
`ifdef IMEM_LOAD_CHECKSUM_EN
        n_checks++; if (ld_csum !== m_csum) begin n_fail++; $display("FAIL run_csum: got %h want %h", ld_csum, m_csum); end
`endif
        step();
    endtask

    // mode 0: ld_done alone, 1: ld_done with last write,
    // 2: idle timeout, 3: ld_done on the very cycle the timeout would fire.
    task automatic test_session(input int unsigned nw, input int unsigned mode, input int unsigned max_gap);
        int n;
        int unsigned nwr;
        nwr = ((mode == 1) && (nw == 0)) ? 1 : nw;
        start_load();
        for (int unsigned i = 0; i < nwr; i++) begin
            repeat ($urandom_range(0, max_gap)) do_idle(1'b0);
            do_write(AW'($urandom), $urandom, ((mode == 1) && (i == nwr - 1)) ? 1'b1 : 1'b0);
        end
        case (mode)
            0: do_idle(1'b1);
            1: ;
            2: begin
                n = 0;
                do begin
                    do_idle(1'b0);
                    n++;
                end while ((cpu_rst !== 1'b1) && (n < int'(TO) + 4));
                n_checks++; if (n != int'(TO)) begin n_fail++; $display("FAIL timeout_len: got %0d want %0d", n, TO); end
            end
            default: begin
                repeat (TO - 1) do_idle(1'b0);
                do_idle(1'b1);
            end
        endcase
        finish_release((mode == 2) ? 1'b1 : 1'b0);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        idle_inputs();
        fetch_addr = AW'(5);
        ld_addr    = '0;
        ld_wdata   = '0;
        n_wr       = 0;
        m_csum     = '0;
        m_err      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        ld_wen   = 1'b1;
        ld_wdata = 32'hA5A5_A5A5;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", mem_we); end
        n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_checks++; if (ld_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", ld_count); end
        n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", ld_err); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL rst_cpurst: got %b want 0", cpu_rst); end
        ld_wen = 1'b0;
        reset  = 1'b0;
        step();
        #1;
        n_checks++; if (mem_addr !== AW'(5)) begin n_fail++; $display("FAIL run_fetch: got %h want 05", mem_addr); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL run_we: got %b want 0", mem_we); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL run_stall0: got %b want 0", cpu_stall); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_busy0: got %b want 0", busy); end
        step();
    endtask

    task automatic test_basic_load();
        start_load();
        do_write(AW'('h10), 32'hDEAD_BEEF, 1'b0);
        #1;
        n_checks++; if (ld_count !== (AW+1)'(1)) begin n_fail++; $display("FAIL first_count: got %0d want 1", ld_count); end
        do_write(AW'('h11), $urandom, 1'b0);
        do_write(AW'('h12), $urandom, 1'b0);
        do_write(AW'('h13), $urandom, 1'b1);
        finish_release(1'b0);
    endtask

    task automatic test_run_ignore();
        for (int i = 0; i < 6; i++) begin
            ld_wen     = 1'b1;
            ld_done    = 1'($urandom_range(0, 1));
            ld_addr    = AW'($urandom);
            ld_wdata   = $urandom;
            fetch_addr = AW'($urandom);
            #1;
            n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ign_we: got %b want 0", mem_we); end
            n_checks++; if (mem_addr !== fetch_addr) begin n_fail++; $display("FAIL ign_addr: got %h want %h", mem_addr, fetch_addr); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy: got %b want 0", busy); end
            step();
        end
        idle_inputs();
        #1;
        n_checks++; if (ld_count !== exp_count(n_wr)) begin n_fail++; $display("FAIL ign_count: got %0d want %0d", ld_count, exp_count(n_wr)); end
        n_checks++; if (ld_err !== m_err) begin n_fail++; $display("FAIL ign_err: got %b want %b", ld_err, m_err); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL ign_stall: got %b want 0", cpu_stall); end
        step();
    endtask

    task automatic test_reset_mid_load();
        start_load();
        do_write(AW'($urandom), $urandom, 1'b0);
        do_write(AW'($urandom), $urandom, 1'b0);
        ld_wen     = 1'b1;
        ld_addr    = AW'($urandom);
        ld_wdata   = $urandom;
        fetch_addr = AW'($urandom);
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL arst_stall: got %b want 0", cpu_stall); end
        n_checks++; if (cpu_rst !== 1'b0) begin n_fail++; $display("FAIL arst_cpurst: got %b want 0", cpu_rst); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL arst_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== fetch_addr) begin n_fail++; $display("FAIL arst_addr: got %h want %h", mem_addr, fetch_addr); end
        n_checks++; if (ld_count !== '0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", ld_count); end
        n_checks++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b want 0", ld_err); end
`ifdef IMEM_LOAD_CHECKSUM_EN
        n_checks++; if (ld_csum !== '0) begin n_fail++; $display("FAIL arst_csum: got %h want 0", ld_csum); end
`endif
        step();
        idle_inputs();
        reset  = 1'b0;
        n_wr   = 0;
        m_csum = '0;
        m_err  = 1'b0;
        step();
    endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
    task automatic test_checksum();
        start_load();
        do_write(AW'(1), 32'h0000_FFFF, 1'b0);
        do_write(AW'(2), 32'hFFFF_0000, 1'b1);
        #1;
        n_checks++; if (ld_csum !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL csum_fixed: got %h want ffffffff", ld_csum); end
        finish_release(1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_load();
        test_session(2, 2, 3);           // idle abort sets ld_err
        test_run_ignore();               // ld_err sticky in RUN
        test_session(1, 0, 2);           // next load clears ld_err in DRAIN
        test_session(0, 2, 0);           // abort with no writes at all
        test_session(3, 3, 3);           // done beats timeout
        for (int i = 0; i < 8; i++) begin
            test_session($urandom_range(0, 6), $urandom_range(0, 3), TO - 1);
        end
        test_run_ignore();
        test_session(CMAX + 3, 1, 0);    // ld_count saturation
        test_reset_mid_load();
        test_session(2, 0, 1);
`ifdef IMEM_LOAD_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
